mcu_read_port: RTL and testbench
================================

# mcu_read_port

Read-back half of the MCU bus. Services MCU read cycles on the same CS/WE/register-select/8-bit-data bus the MCU uses for pixel writes: holds a pixel address loaded by MCU register writes, prefetches the addressed pixel from the memory manager over a request/complete handshake, and drives it onto the MCU data bus. A read of the data register auto-advances the address and prefetches the next pixel, so sequential framebuffer reads need no address rewrites.

## Interface
- WIDTH, 320, pixels per line; X wraps at WIDTH-1
- HEIGHT, 240, lines; Y wraps at HEIGHT-1
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low (asserted at 0)
- mpuChipSelect  in  1  MCU chip select, active high, asynchronous to clock
- mpuWriteEnable  in  1  0 = MCU write cycle, 1 = MCU read cycle
- mpuRegisterSelect  in  3  register index
- mpuDataBus  inout  8  MCU data bus
- memoryReadAddress  out  17  {Y[7:0], X[8:0]}
- memoryReadRequest  out  1  read request to memory manager
- memoryReadData  in  8  pixel from memory manager
- memoryReadComplete  in  1  memory manager: data valid this cycle

## Operation
- Registers: 0 X[7:0] (R/W); 1 X[8] in bit 0 (R/W, other bits read 0); 2 Y (R/W); 3 DATA (R: prefetched pixel; W ignored); 4 STATUS (R only: bit0 dataValid, bit1 busy, bits 7:2 zero); 5-7 read 0, writes ignored.
- Write strobe = CS && !WE; read strobe = CS && WE. Both pass through 2-flop synchronisers (s1, s2).
- Write: while synchronised write strobe s1 high, mpuDataBus captured into a holding register each cycle; on falling edge (s2=1, s1=0) holding register committed to the selected register. Any commit to 0/1/2 clears dataValid and triggers a prefetch.
- Read: mpuDataBus driven whenever raw CS && WE (combinational enable, not synchronised), value = registered read mux of mpuRegisterSelect; otherwise high-Z. DATA read with dataValid=0 returns last data register contents.
- On falling edge of synchronised read strobe with register 3 selected: address advances (X+1; at X=WIDTH-1 → X=0, Y+1; at Y=HEIGHT-1 also → Y=0), dataValid cleared, prefetch triggered.
- Prefetch FSM: IDLE → REQUEST on trigger. REQUEST: memoryReadRequest=1, memoryReadAddress stable. On memoryReadComplete=1: data register ← memoryReadData, → IDLE, dataValid=1, unless a stale flag is set (see below).
- Trigger during REQUEST (address changed mid-fetch): set stale flag; returned data discarded, dataValid stays 0, FSM re-enters REQUEST with new address after one IDLE cycle, flag cleared.
- busy = FSM in REQUEST or stale-refetch pending.

## Timing
- Reset values: memoryReadAddress 0, memoryReadRequest 0, data register 0, dataValid 0, stale 0, address regs 0, FSM IDLE, mpuDataBus high-Z unless raw read strobe high.
- First clock after reset deassertion: prefetch of address 0 triggered; memoryReadRequest high on following cycle.
- Register commit: 2-3 clocks after write strobe falls at pins (synchroniser uncertainty). memoryReadRequest rises 1 clock after commit.
- memoryReadAddress updates only while memoryReadRequest=0; held constant through REQUEST.
- memoryReadRequest drops the cycle after memoryReadComplete is sampled; never re-asserted in the same cycle complete is seen. Minimum 1 low cycle between requests.
- dataValid rises the clock after memoryReadComplete; DATA readback presents new value from that cycle.
- memoryReadComplete while IDLE: ignored.
- Reset asserted mid-REQUEST: request drops immediately (async), no data latched.

## Test plan
- Reset then no MCU activity -> one request at address 0; memory returns 0x5A with complete -> STATUS reads 0x01, DATA reads 0x5A.
- Write X_LOW=0x3F, X_HIGH=0x01, Y=0x02 -> memoryReadAddress 0x0053F requested after final commit; each commit 2-3 clocks after strobe falls.
- Set X=319, Y=5, prefetch done; read DATA -> next request at X=0, Y=6 (0x00C00); at X=319, Y=239 -> wraps to 0x00000.
- Write Y while request outstanding with complete delayed 10 clocks -> first returned byte discarded, STATUS bit1=1 throughout, second request carries new address, dataValid set only after second complete.
- Read STATUS during fetch -> 0x02; bus high-Z whenever CS=0 or WE=0; registers 5-7 read 0x00; write to DATA leaves address and data unchanged.
- Assert reset mid-REQUEST -> memoryReadRequest 0 with no clock edge; after release, fresh fetch of address 0.

Source files
------------

// File: rtl/mcu_read_port.sv
// Read-back half of the MCU bus: pixel address registers, one-pixel prefetch, auto-advance on DATA reads.
// Commit lands 2-3 clocks after the strobe and the request 1 clock later; the request is held until memory completes.
module mcu_read_port #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mpuChipSelect,
    input  logic        mpuWriteEnable,
    input  logic [2:0]  mpuRegisterSelect,
    inout  wire  [7:0]  mpuDataBus,
    output logic [16:0] memoryReadAddress,
    output logic        memoryReadRequest,
    input  logic [7:0]  memoryReadData,
    input  logic        memoryReadComplete
);

    typedef enum logic {IDLE, REQUEST} fetchState_e;

    localparam logic [8:0] X_LAST = 9'(WIDTH - 1);
    localparam logic [7:0] Y_LAST = 8'(HEIGHT - 1);

    fetchState_e state, nextState;

    logic       wrS1, wrS2, rdS1, rdS2;
    logic [7:0] holdData;
    logic [2:0] holdSel, readSel;
    logic [8:0] xPos;
    logic [7:0] yPos;
    logic [7:0] dataReg, readMux;
    logic       dataValid, stale, pending, initDone;

    logic writeCommit, readAdvance, addrCommit, trigger, launch, fetchGood, busy;

    assign writeCommit = wrS2 && !wrS1;
    assign readAdvance = rdS2 && !rdS1 && (readSel == 3'd3);
    assign addrCommit  = writeCommit && (holdSel <= 3'd2);
    // The first clock out of reset behaves like an address write so address 0 is prefetched.
    assign trigger     = addrCommit || readAdvance || !initDone;
    assign launch      = (state == IDLE) && pending;
    assign fetchGood   = (state == REQUEST) && memoryReadComplete && !stale && !trigger;
    assign busy        = (state == REQUEST) || pending;

    // Strobes are synchronised; bus data and select are sampled while the strobe is seen high.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wrS1     <= 1'b0;
            wrS2     <= 1'b0;
            rdS1     <= 1'b0;
            rdS2     <= 1'b0;
            holdData <= 8'd0;
            holdSel  <= 3'd0;
            readSel  <= 3'd0;
        end else begin
            wrS1 <= mpuChipSelect && !mpuWriteEnable;
            wrS2 <= wrS1;
            rdS1 <= mpuChipSelect && mpuWriteEnable;
            rdS2 <= rdS1;
            if (wrS1) begin
                holdData <= mpuDataBus;
                holdSel  <= mpuRegisterSelect;
            end
            if (rdS1) begin
                readSel <= mpuRegisterSelect;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            xPos <= 9'd0;
            yPos <= 8'd0;
        end else if (writeCommit) begin
            case (holdSel)
                3'd0:    xPos[7:0] <= holdData;
                3'd1:    xPos[8]   <= holdData[0];
                3'd2:    yPos      <= holdData;
                default: ;
            endcase
        end else if (readAdvance) begin
            if (xPos >= X_LAST) begin
                xPos <= 9'd0;
                yPos <= (yPos >= Y_LAST) ? 8'd0 : yPos + 8'd1;
            end else begin
                xPos <= xPos + 9'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState         = state;
        memoryReadRequest = 1'b0;
        case (state)
            IDLE: begin
                if (pending) begin
                    nextState = REQUEST;
                end
            end
            REQUEST: begin
                memoryReadRequest = 1'b1;
                if (memoryReadComplete) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // An address change while a fetch is in flight marks it stale; pending then forces a refetch.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            initDone          <= 1'b0;
            pending           <= 1'b0;
            stale             <= 1'b0;
            dataValid         <= 1'b0;
            dataReg           <= 8'd0;
            memoryReadAddress <= 17'd0;
        end else begin
            initDone <= 1'b1;
            if (launch) begin
                memoryReadAddress <= {yPos, xPos};
                pending           <= trigger;
                stale             <= trigger;
            end else begin
                if (trigger) begin
                    pending <= 1'b1;
                end
                if (state == REQUEST) begin
                    if (memoryReadComplete) begin
                        stale <= 1'b0;
                    end else if (trigger) begin
                        stale <= 1'b1;
                    end
                end
            end
            if (trigger) begin
                dataValid <= 1'b0;
            end else if (fetchGood) begin
                dataValid <= 1'b1;
            end
            if (fetchGood) begin
                dataReg <= memoryReadData;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            readMux <= 8'd0;
        end else begin
            case (mpuRegisterSelect)
                3'd0:    readMux <= xPos[7:0];
                3'd1:    readMux <= {7'd0, xPos[8]};
                3'd2:    readMux <= yPos;
                3'd3:    readMux <= dataReg;
                3'd4:    readMux <= {6'd0, busy, dataValid};
                default: readMux <= 8'd0;
            endcase
        end
    end

    // Output enable follows the raw pins so the MCU sees data within its own read cycle.
    assign mpuDataBus = (mpuChipSelect && mpuWriteEnable) ? readMux : 8'hzz;

endmodule

// File: tb/tb_mcu_read_port.sv
// Directed bench for mcu_read_port: MCU bus tasks plus a latency-programmable memory responder.
module tb_mcu_read_port;

    logic        clock = 1'b0;
    logic        reset;
    logic        cs, we;
    logic [2:0]  sel;
    tri1  [7:0]  bus;
    logic [7:0]  busDrive;
    logic        busDriveEn;
    logic [16:0] memAddr;
    logic        memReq;
    logic [7:0]  memData;
    logic        memComplete;

    int          total = 0;
    int          bad = 0;
    int          memLatency = 0;
    logic        memEnable = 1'b0;
    logic [7:0]  memBase = 8'd0;
    logic        strayPulse = 1'b0;
    int          reqCount = 0;
    logic [16:0] reqAddr = 17'd0;
    int          addrMoves = 0;

    assign bus = busDriveEn ? busDrive : 8'hzz;

    mcu_read_port #(.WIDTH(320), .HEIGHT(240)) dut (
        .clock              (clock),
        .reset              (reset),
        .mpuChipSelect      (cs),
        .mpuWriteEnable     (we),
        .mpuRegisterSelect  (sel),
        .mpuDataBus         (bus),
        .memoryReadAddress  (memAddr),
        .memoryReadRequest  (memReq),
        .memoryReadData     (memData),
        .memoryReadComplete (memComplete)
    );

    always #5 clock = ~clock;

    // Memory: answers with memBase + Y after memLatency request cycles; logs each new request.
    initial begin : memModel
        int   waitCnt;
        logic prevReq;
        waitCnt     = 0;
        prevReq     = 1'b0;
        memComplete = 1'b0;
        memData     = 8'd0;
        forever begin
            @(negedge clock);
            memComplete = 1'b0;
            if (memReq && !prevReq) begin
                reqCount++;
                reqAddr = memAddr;
            end
            if (memReq && prevReq && memAddr != reqAddr) addrMoves++;
            prevReq = memReq;
            if (strayPulse) begin
                memComplete = 1'b1;
                memData     = 8'hEE;
                strayPulse  = 1'b0;
            end else if (memEnable && memReq) begin
                if (waitCnt >= memLatency) begin
                    memComplete = 1'b1;
                    memData     = memBase + memAddr[16:9];
                    waitCnt     = 0;
                end else begin
                    waitCnt++;
                end
            end else begin
                waitCnt = 0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    // Write cycle; rise = negedges after CS falls until a fresh request appears (99 if none).
    task automatic mcuWrite(input logic [2:0] s, input logic [7:0] d, output int rise);
        logic seenLow;
        rise = 99;
        cs = 1'b1; we = 1'b0; sel = s; busDrive = d; busDriveEn = 1'b1;
        repeat (3) @(negedge clock);
        cs = 1'b0;
        seenLow = !memReq;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clock);
            if (i == 2) begin
                busDriveEn = 1'b0;
                we = 1'b1;
            end
            if (memReq && seenLow && rise == 99) rise = i;
            if (!memReq) seenLow = 1'b1;
        end
    endtask

    task automatic mcuRead(input logic [2:0] s, output logic [7:0] v);
        cs = 1'b1; we = 1'b1; sel = s; busDriveEn = 1'b0;
        repeat (2) @(negedge clock);
        v = bus;
        cs = 1'b0;
        repeat (6) @(negedge clock);
    endtask

    task automatic waitIdle(output bit timedOut);
        int n;
        n = 0;
        repeat (2) @(negedge clock);
        while (memReq && n < 80) begin
            @(negedge clock);
            n++;
        end
        timedOut = memReq;
    endtask

    task automatic test_reset();
        reset = 1'b0; cs = 1'b0; we = 1'b1; sel = 3'd0; busDriveEn = 1'b0; busDrive = 8'd0;
        repeat (3) @(negedge clock);
        total++; if (memReq !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", memReq); end
        total++; if (memAddr !== 17'd0) begin bad++; $display("FAIL rst_addr: got %h want 0", memAddr); end
        total++; if (bus !== 8'hFF) begin bad++; $display("FAIL rst_bus_hiz: got %h want ff", bus); end
        reset = 1'b1;
        @(negedge clock);
        total++; if (memReq !== 1'b0) begin bad++; $display("FAIL init_req_early: got %b want 0", memReq); end
        @(negedge clock);
        total++; if (memReq !== 1'b1) begin bad++; $display("FAIL init_req: got %b want 1", memReq); end
        total++; if (memAddr !== 17'd0) begin bad++; $display("FAIL init_addr: got %h want 0", memAddr); end
    endtask

    task automatic test_first_fetch();
        bit to;
        logic [7:0] v;
        memBase = 8'h5A; memLatency = 0; memEnable = 1'b1;
        waitIdle(to);
        total++; if (to) begin bad++; $display("FAIL first_idle: request stuck high"); end
        mcuRead(3'd4, v);
        total++; if (v !== 8'h01) begin bad++; $display("FAIL first_status: got %h want 01", v); end
        mcuRead(3'd3, v);
        total++; if (v !== 8'h5A) begin bad++; $display("FAIL first_data: got %h want 5a", v); end
        total++; if (reqAddr !== 17'h00001) begin bad++; $display("FAIL advance_addr: got %h want 00001", reqAddr); end
        total++; if (reqCount !== 2) begin bad++; $display("FAIL advance_count: got %0d want 2", reqCount); end
    endtask

    task automatic test_addr_write();
        int r;
        logic [7:0] v;
        mcuWrite(3'd0, 8'h3F, r);
        total++; if (r < 3 || r > 4) begin bad++; $display("FAIL commit_xlo: got %0d want 3..4", r); end
        mcuWrite(3'd1, 8'h01, r);
        total++; if (r < 3 || r > 4) begin bad++; $display("FAIL commit_xhi: got %0d want 3..4", r); end
        mcuWrite(3'd2, 8'h02, r);
        total++; if (r < 3 || r > 4) begin bad++; $display("FAIL commit_y: got %0d want 3..4", r); end
        total++; if (reqAddr !== 17'h0053F) begin bad++; $display("FAIL write_addr: got %h want 0053f", reqAddr); end
        mcuRead(3'd0, v);
        total++; if (v !== 8'h3F) begin bad++; $display("FAIL rd_xlo: got %h want 3f", v); end
        mcuRead(3'd1, v);
        total++; if (v !== 8'h01) begin bad++; $display("FAIL rd_xhi: got %h want 01", v); end
        mcuRead(3'd2, v);
        total++; if (v !== 8'h02) begin bad++; $display("FAIL rd_y: got %h want 02", v); end
    endtask

    task automatic test_wrap();
        int r;
        logic [7:0] v;
        memBase = 8'h20;
        mcuWrite(3'd2, 8'h05, r);
        mcuRead(3'd3, v);
        total++; if (v !== 8'h25) begin bad++; $display("FAIL wrap_data: got %h want 25", v); end
        total++; if (reqAddr !== 17'h00C00) begin bad++; $display("FAIL wrap_x: got %h want 00c00", reqAddr); end
        mcuWrite(3'd2, 8'hEF, r);
        mcuWrite(3'd1, 8'h01, r);
        mcuWrite(3'd0, 8'h3F, r);
        total++; if (reqAddr !== 17'h1DF3F) begin bad++; $display("FAIL corner_addr: got %h want 1df3f", reqAddr); end
        mcuRead(3'd3, v);
        total++; if (v !== 8'h0F) begin bad++; $display("FAIL corner_data: got %h want 0f", v); end
        total++; if (reqAddr !== 17'h00000) begin bad++; $display("FAIL wrap_xy: got %h want 00000", reqAddr); end
    endtask

    task automatic test_stale();
        int r, c0;
        bit to;
        logic [7:0] v;
        memBase = 8'h40; memLatency = 12;
        c0 = reqCount;
        mcuWrite(3'd2, 8'h07, r);
        mcuWrite(3'd2, 8'h08, r);
        mcuRead(3'd4, v);
        total++; if (v !== 8'h02) begin bad++; $display("FAIL stale_status: got %h want 02", v); end
        waitIdle(to);
        total++; if (to) begin bad++; $display("FAIL stale_idle: request stuck high"); end
        total++; if (reqCount - c0 !== 2) begin bad++; $display("FAIL stale_count: got %0d want 2", reqCount - c0); end
        total++; if (reqAddr !== 17'h01000) begin bad++; $display("FAIL stale_addr: got %h want 01000", reqAddr); end
        mcuRead(3'd4, v);
        total++; if (v !== 8'h01) begin bad++; $display("FAIL stale_done: got %h want 01", v); end
        total++; if (addrMoves !== 0) begin bad++; $display("FAIL addr_stable: got %0d moves want 0", addrMoves); end
        memLatency = 0;
    endtask

    task automatic test_bus_misc();
        int r, c0;
        logic [7:0] v;
        cs = 1'b0; we = 1'b1; sel = 3'd4;
        repeat (2) @(negedge clock);
        total++; if (bus !== 8'hFF) begin bad++; $display("FAIL hiz_nocs: got %h want ff", bus); end
        cs = 1'b1; we = 1'b0; sel = 3'd5; busDriveEn = 1'b0;
        repeat (2) @(negedge clock);
        total++; if (bus !== 8'hFF) begin bad++; $display("FAIL hiz_write: got %h want ff", bus); end
        cs = 1'b0;
        repeat (2) @(negedge clock);
        we = 1'b1;
        repeat (4) @(negedge clock);
        for (int i = 5; i <= 7; i++) begin
            mcuRead(3'(i), v);
            total++; if (v !== 8'h00) begin bad++; $display("FAIL rd_reg%0d: got %h want 00", i, v); end
        end
        c0 = reqCount;
        mcuWrite(3'd3, 8'h99, r);
        total++; if (reqCount !== c0) begin bad++; $display("FAIL data_write_fetch: got %0d want %0d", reqCount, c0); end
        mcuRead(3'd0, v);
        total++; if (v !== 8'h00) begin bad++; $display("FAIL data_write_x: got %h want 00", v); end
        mcuRead(3'd2, v);
        total++; if (v !== 8'h08) begin bad++; $display("FAIL data_write_y: got %h want 08", v); end
        strayPulse = 1'b1;
        repeat (3) @(negedge clock);
        mcuRead(3'd3, v);
        total++; if (v !== 8'h48) begin bad++; $display("FAIL data_keep: got %h want 48", v); end
    endtask

    task automatic test_reset_mid();
        int r;
        bit to;
        logic [7:0] v;
        memEnable = 1'b0;
        mcuWrite(3'd0, 8'h05, r);
        total++; if (memReq !== 1'b1) begin bad++; $display("FAIL mid_req_held: got %b want 1", memReq); end
        #2;
        reset = 1'b0;
        #1;
        total++; if (memReq !== 1'b0) begin bad++; $display("FAIL mid_req_drop: got %b want 0", memReq); end
        total++; if (memAddr !== 17'd0) begin bad++; $display("FAIL mid_addr: got %h want 0", memAddr); end
        @(negedge clock);
        reset = 1'b1; memBase = 8'h10; memEnable = 1'b1;
        repeat (3) @(negedge clock);
        waitIdle(to);
        total++; if (to) begin bad++; $display("FAIL mid_idle: request stuck high"); end
        total++; if (reqAddr !== 17'd0) begin bad++; $display("FAIL mid_refetch: got %h want 0", reqAddr); end
        mcuRead(3'd0, v);
        total++; if (v !== 8'h00) begin bad++; $display("FAIL mid_x: got %h want 00", v); end
        mcuRead(3'd3, v);
        total++; if (v !== 8'h10) begin bad++; $display("FAIL mid_data: got %h want 10", v); end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_addr_write();
        test_wrap();
        test_stale();
        test_bus_misc();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
